// File: rtl/j11sram_if.sv
// J11 bridge memory request bus: single-cycle request, single-cycle ack.
// Carries memperr only when J11SRAM_PARITY_EN is defined.
interface j11sram_if;
    logic        memreq;
    logic        memwr;
    logic [21:0] memaddr;
    logic [15:0] memwdata;
    logic        memack;
    logic [15:0] memrdata;
    logic        memovf;
`ifdef J11SRAM_PARITY_EN
    logic        memperr;

    modport master (output memreq, memwr, memaddr, memwdata,
                    input  memack, memrdata, memovf, memperr);
    modport slave  (input  memreq, memwr, memaddr, memwdata,
                    output memack, memrdata, memovf, memperr);
`else
    modport master (output memreq, memwr, memaddr, memwdata,
                    input  memack, memrdata, memovf);
    modport slave  (input  memreq, memwr, memaddr, memwdata,
                    output memack, memrdata, memovf);
`endif
endinterface

// File: rtl/j11sram.sv
// Asynchronous SRAM responder for the J11 bridge memory bus with programmable wait states.
// Optional byte parity on the SRAM data path: define J11SRAM_PARITY_EN.
module j11sram #(
    parameter int ADDR_W  = 21,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1,
`ifdef J11SRAM_PARITY_EN
    localparam int DQ_W   = 18
`else
    localparam int DQ_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    j11sram_if.slave          bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DQ_W-1:0]   sram_dq_o,
    input  logic [DQ_W-1:0]   sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    // RDONE is the read's ack cycle: strobes already released, data on memrdata.
    typedef enum logic [2:0] {IDLE, RD, RDONE, WSETUP, WPULSE, WHOLD, REC} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               pend_vld;
    logic               pend_wr;
    logic [ADDR_W-1:0]  pend_addr;
    logic [15:0]        pend_wdata;

    logic               busy, fin, use_pend, go, go_wr;
    logic [ADDR_W-1:0]  go_addr;
    logic [15:0]        go_wdata;

    function automatic logic [DQ_W-1:0] enc(input logic [15:0] d);
`ifdef J11SRAM_PARITY_EN
        return {~^d[15:8], ~^d[7:0], d};
`else
        return d;
`endif
    endfunction

    // fin marks the cycle whose closing edge may launch the next access.
    always_comb begin
        busy     = (state != IDLE);
        fin      = (state == IDLE) || (state == REC && cnt == 4'd1) ||
                   ((state == RDONE || state == WHOLD) && TURN == 0);
        use_pend = busy && pend_vld;
        go       = fin && (use_pend || bus.memreq);
        go_wr    = use_pend ? pend_wr    : bus.memwr;
        go_addr  = use_pend ? pend_addr  : bus.memaddr[ADDR_W:1];
        go_wdata = use_pend ? pend_wdata : bus.memwdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            pend_vld     <= 1'b0;
            pend_wr      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            bus.memack   <= 1'b0;
            bus.memrdata <= '0;
            bus.memovf   <= 1'b0;
`ifdef J11SRAM_PARITY_EN
            bus.memperr  <= 1'b0;
`endif
            sram_addr    <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
        end else begin
            bus.memack <= 1'b0;
`ifdef J11SRAM_PARITY_EN
            bus.memperr <= 1'b0;
`endif
            // A slot being drained this cycle may be refilled in the same edge.
            if (bus.memreq && busy) begin
                if (pend_vld && !fin) begin
                    bus.memovf <= 1'b1;
                end else if (pend_vld || !fin) begin
                    pend_vld   <= 1'b1;
                    pend_wr    <= bus.memwr;
                    pend_addr  <= bus.memaddr[ADDR_W:1];
                    pend_wdata <= bus.memwdata;
                end
            end else if (pend_vld && fin) begin
                pend_vld <= 1'b0;
            end

            if (go) begin
                state      <= go_wr ? WSETUP : RD;
                cnt        <= 4'(RD_WAIT);
                sram_addr  <= go_addr;
                sram_ce_n  <= 1'b0;
                sram_oe_n  <= go_wr;
                sram_we_n  <= 1'b1;
                sram_dq_oe <= go_wr;
                if (go_wr)
                    sram_dq_o <= enc(go_wdata);
            end else if (fin) begin
                state      <= IDLE;
                sram_ce_n  <= 1'b1;
                sram_oe_n  <= 1'b1;
                sram_we_n  <= 1'b1;
                sram_dq_oe <= 1'b0;
            end else begin
                case (state)
                    RD: begin
                        if (cnt == 4'd1) begin
                            bus.memrdata <= sram_dq_i[15:0];
                            bus.memack   <= 1'b1;
`ifdef J11SRAM_PARITY_EN
                            bus.memperr  <= (sram_dq_i[16] == ^sram_dq_i[7:0]) ||
                                            (sram_dq_i[17] == ^sram_dq_i[15:8]);
`endif
                            sram_ce_n    <= 1'b1;
                            sram_oe_n    <= 1'b1;
                            state        <= RDONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    RDONE: begin
                        state <= REC;
                        cnt   <= 4'(TURN);
                    end
                    WSETUP: begin
                        state     <= WPULSE;
                        sram_we_n <= 1'b0;
                        cnt       <= 4'(WR_WAIT);
                    end
                    WPULSE: begin
                        if (cnt == 4'd1) begin
                            sram_we_n  <= 1'b1;
                            bus.memack <= 1'b1;
                            state      <= WHOLD;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    WHOLD: begin
                        sram_ce_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        state      <= REC;
                        cnt        <= 4'(TURN);
                    end
                    REC:     cnt   <= cnt - 4'd1;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_j11sram.sv
// Directed bench for j11sram: reset, read/write timing, pending slot, overflow, mid-access reset.
// Parity scenario is compiled in when J11SRAM_PARITY_EN is defined.
module tb_j11sram;
`ifdef J11SRAM_PARITY_EN
    localparam int DQ_W = 18;
`else
    localparam int DQ_W = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    j11sram_if bus();
    logic [20:0]     sram_addr;
    logic [DQ_W-1:0] sram_dq_o, sram_dq_i;
    logic            sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [DQ_W-1:0] mem [logic [20:0]];
    logic [DQ_W-1:0] corrupt = '0;
    int n_pass = 0;
    int n_tot  = 0;

    j11sram dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    // SRAM model: write while we_n low, read data settles half a cycle after strobes change.
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_dq_o;
    always @(negedge clk)
        sram_dq_i <= (!sram_ce_n && !sram_oe_n && mem.exists(sram_addr)) ? (mem[sram_addr] ^ corrupt) : '0;

    function automatic logic [DQ_W-1:0] pw(input logic [15:0] d);
`ifdef J11SRAM_PARITY_EN
        return {~^d[15:8], ~^d[7:0], d};
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic req(input logic wr, input logic [21:0] a, input logic [15:0] d);
        bus.memreq = 1'b1; bus.memwr = wr; bus.memaddr = a; bus.memwdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.memreq = 1'b0; bus.memwr = 1'b0; bus.memaddr = '0; bus.memwdata = '0;
        repeat (3) step();
        n_tot++; if (bus.memack !== 1'b0) $display("FAIL rst_ack got %b want 0", bus.memack); else n_pass++;
        n_tot++; if (bus.memrdata !== 16'h0) $display("FAIL rst_rdata got %h want 0000", bus.memrdata); else n_pass++;
        n_tot++; if (bus.memovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", bus.memovf); else n_pass++;
        n_tot++; if (sram_addr !== 21'h0) $display("FAIL rst_addr got %h want 0", sram_addr); else n_pass++;
        n_tot++; if (sram_dq_o !== '0 || sram_dq_oe !== 1'b0) $display("FAIL rst_dq got %h/%b want 0/0", sram_dq_o, sram_dq_oe); else n_pass++;
        n_tot++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) $display("FAIL rst_strobes got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); else n_pass++;
`ifdef J11SRAM_PARITY_EN
        n_tot++; if (bus.memperr !== 1'b0) $display("FAIL rst_perr got %b want 0", bus.memperr); else n_pass++;
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        req(1'b0, 22'h000246, 16'h0);
        step(); bus.memreq = 1'b0;                                   // cycle 1
        n_tot++; if (sram_addr !== 21'h00123) $display("FAIL rd_addr got %h want 00123", sram_addr); else n_pass++;
        n_tot++; if ({sram_ce_n, sram_oe_n} !== 2'b00) $display("FAIL rd_c1_strobes got %b want 00", {sram_ce_n, sram_oe_n}); else n_pass++;
        step();                                                      // cycle 2
        n_tot++; if (sram_oe_n !== 1'b0 || bus.memack !== 1'b0) $display("FAIL rd_c2 got oe_n=%b ack=%b want 0/0", sram_oe_n, bus.memack); else n_pass++;
        step();                                                      // cycle 3
        n_tot++; if (bus.memack !== 1'b1) $display("FAIL rd_ack got %b want 1", bus.memack); else n_pass++;
        n_tot++; if (bus.memrdata !== 16'hBEEF) $display("FAIL rd_data got %h want BEEF", bus.memrdata); else n_pass++;
`ifdef J11SRAM_PARITY_EN
        n_tot++; if (bus.memperr !== 1'b0) $display("FAIL rd_perr got %b want 0", bus.memperr); else n_pass++;
`endif
        req(1'b0, 22'h000248, 16'h0);                                // request alongside memack
        step(); bus.memreq = 1'b0;                                   // cycle 4: recovery
        n_tot++; if (sram_oe_n !== 1'b1 || bus.memack !== 1'b0) $display("FAIL rd_rec got oe_n=%b ack=%b want 1/0", sram_oe_n, bus.memack); else n_pass++;
        step();                                                      // cycle 5
        n_tot++; if (sram_oe_n !== 1'b0 || sram_addr !== 21'h00124) $display("FAIL rd_next got oe_n=%b addr=%h want 0/00124", sram_oe_n, sram_addr); else n_pass++;
        step(); step();                                              // cycle 7
        n_tot++; if (bus.memack !== 1'b1 || bus.memrdata !== 16'h5A5A) $display("FAIL rd_next_ack got %b/%h want 1/5A5A", bus.memack, bus.memrdata); else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_write();
        req(1'b1, 22'h3FFFFE, 16'h1234);
        step(); bus.memreq = 1'b0;                                   // cycle 1
        n_tot++; if (sram_dq_oe !== 1'b1 || sram_we_n !== 1'b1 || sram_ce_n !== 1'b0) $display("FAIL wr_setup got oe=%b we_n=%b ce_n=%b want 1/1/0", sram_dq_oe, sram_we_n, sram_ce_n); else n_pass++;
        n_tot++; if (sram_addr !== 21'h1FFFFF) $display("FAIL wr_addr got %h want 1FFFFF", sram_addr); else n_pass++;
        n_tot++; if (sram_dq_o[15:0] !== 16'h1234) $display("FAIL wr_dq got %h want 1234", sram_dq_o[15:0]); else n_pass++;
        step();                                                      // cycle 2
        n_tot++; if (sram_we_n !== 1'b0) $display("FAIL wr_pulse2 got %b want 0", sram_we_n); else n_pass++;
        step();                                                      // cycle 3
        n_tot++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || bus.memack !== 1'b0) $display("FAIL wr_pulse3 got we_n=%b oe=%b ack=%b want 0/1/0", sram_we_n, sram_dq_oe, bus.memack); else n_pass++;
        step();                                                      // cycle 4
        n_tot++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b1) $display("FAIL wr_hold got we_n=%b oe=%b want 1/1", sram_we_n, sram_dq_oe); else n_pass++;
        n_tot++; if (bus.memack !== 1'b1) $display("FAIL wr_ack got %b want 1", bus.memack); else n_pass++;
        n_tot++; if (bus.memrdata !== 16'h5A5A) $display("FAIL wr_rdata_kept got %h want 5A5A", bus.memrdata); else n_pass++;
        step();                                                      // cycle 5
        n_tot++; if (sram_dq_oe !== 1'b0 || bus.memack !== 1'b0) $display("FAIL wr_release got oe=%b ack=%b want 0/0", sram_dq_oe, bus.memack); else n_pass++;
        repeat (2) step();
        req(1'b0, 22'h3FFFFE, 16'h0);
        step(); bus.memreq = 1'b0;
        step(); step();
        n_tot++; if (bus.memack !== 1'b1 || bus.memrdata !== 16'h1234) $display("FAIL wr_readback got %b/%h want 1/1234", bus.memack, bus.memrdata); else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_pending();
        int acks = 0;
        int c1 = -1;
        int c2 = -1;
        logic [15:0] d2 = '0;
        req(1'b1, 22'h000100, 16'hCAFE);
        step(); bus.memreq = 1'b0;
        step(); req(1'b0, 22'h000100, 16'h0);                        // cycle 2
        step(); bus.memreq = 1'b0;                                   // cycle 3
        for (int c = 3; c < 15; c++) begin
            if (bus.memack === 1'b1) begin
                acks++;
                if (acks == 1) c1 = c;
                else begin c2 = c; d2 = bus.memrdata; end
            end
            step();
        end
        n_tot++; if (acks != 2) $display("FAIL pend_acks got %0d want 2", acks); else n_pass++;
        n_tot++; if (c1 != 4) $display("FAIL pend_wr_ack_cycle got %0d want 4", c1); else n_pass++;
        n_tot++; if (c2 != 8) $display("FAIL pend_rd_ack_cycle got %0d want 8", c2); else n_pass++;
        n_tot++; if (d2 !== 16'hCAFE) $display("FAIL pend_rd_data got %h want CAFE", d2); else n_pass++;
        n_tot++; if (bus.memovf !== 1'b0) $display("FAIL pend_ovf got %b want 0", bus.memovf); else n_pass++;
    endtask

    task automatic test_overflow();
        int acks = 0;
        req(1'b0, 22'h000246, 16'h0);
        step(); req(1'b0, 22'h000248, 16'h0);                        // cycle 1
        step(); req(1'b0, 22'h000246, 16'h0);                        // cycle 2
        n_tot++; if (bus.memovf !== 1'b0) $display("FAIL ovf_early got %b want 0", bus.memovf); else n_pass++;
        step(); bus.memreq = 1'b0;                                   // cycle 3
        n_tot++; if (bus.memovf !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.memovf); else n_pass++;
        for (int c = 3; c < 25; c++) begin
            if (bus.memack === 1'b1) acks++;
            step();
        end
        n_tot++; if (acks != 2) $display("FAIL ovf_acks got %0d want 2", acks); else n_pass++;
        n_tot++; if (bus.memovf !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.memovf); else n_pass++;
        rst = 1'b1;
        step(); rst = 1'b0;
        n_tot++; if (bus.memovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", bus.memovf); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        req(1'b0, 22'h000246, 16'h0);
        step(); bus.memreq = 1'b0;
        step();                                                      // cycle 2
        n_tot++; if (sram_oe_n !== 1'b0) $display("FAIL rstmid_reading got %b want 0", sram_oe_n); else n_pass++;
        rst = 1'b1;
        step(); rst = 1'b0;                                          // cycle 3
        n_tot++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111 || sram_dq_oe !== 1'b0) $display("FAIL rstmid_strobes got %b/%b want 111/0", {sram_ce_n, sram_oe_n, sram_we_n}, sram_dq_oe); else n_pass++;
        n_tot++; if (bus.memack !== 1'b0) $display("FAIL rstmid_ack got %b want 0", bus.memack); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            if (bus.memack === 1'b1) acks++;
            step();
        end
        n_tot++; if (acks != 0) $display("FAIL rstmid_stale_ack got %0d want 0", acks); else n_pass++;
    endtask

`ifdef J11SRAM_PARITY_EN
    task automatic test_parity();
        req(1'b1, 22'h000010, 16'h00FF);
        step(); bus.memreq = 1'b0;
        repeat (6) step();
        n_tot++; if (mem[21'h8] !== 18'h300FF) $display("FAIL par_stored got %h want 300FF", mem[21'h8]); else n_pass++;
        corrupt = 18'h1;
        req(1'b0, 22'h000010, 16'h0);
        step(); bus.memreq = 1'b0;
        step(); step();
        n_tot++; if ({bus.memack, bus.memperr} !== 2'b11) $display("FAIL par_err got %b want 11", {bus.memack, bus.memperr}); else n_pass++;
        n_tot++; if (bus.memrdata !== 16'h00FE) $display("FAIL par_data got %h want 00FE", bus.memrdata); else n_pass++;
        corrupt = '0;
        repeat (3) step();
    endtask
`endif

    initial begin
        mem[21'h00123] = pw(16'hBEEF);
        mem[21'h00124] = pw(16'h5A5A);
        test_reset();
        test_read();
        test_write();
        test_pending();
        test_overflow();
        test_reset_mid();
`ifdef J11SRAM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
